// File: rtl/dice_judge.sv
// rtl/dice_judge.sv - N-channel dice round evaluator driving digit/pattern to the 7-seg driver.
// Optional round timeout compiled in with DICE_JUDGE_TIMEOUT_EN.
module dice_judge #(
  parameter int N_DICE      = 2,
  parameter int VAL_W       = 3,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_DICE*VAL_W-1:0]   dice_in,
  input  logic [N_DICE-1:0]         rolled_in,
  output logic [VAL_W:0]            digit,
  output logic [1:0]                pattern,
  output logic                      result_valid,
  output logic [CNT_W-1:0]          round_cnt,
  output logic                      timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EVAL    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [N_DICE-1:0]   flags_q, flags_d;
  logic [VAL_W:0]      digit_q, digit_d;
  logic [1:0]          pattern_q, pattern_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;

  logic all_equal, any_one, any_two, any_three;

  always_comb begin
    all_equal = 1'b1;
    any_one   = 1'b0;
    any_two   = 1'b0;
    any_three = 1'b0;
    for (int i = 0; i < N_DICE; i++) begin
      if (dice_in[i*VAL_W +: VAL_W] != dice_in[0 +: VAL_W]) all_equal = 1'b0;
      if (dice_in[i*VAL_W +: VAL_W] == VAL_W'(1)) any_one   = 1'b1;
      if (dice_in[i*VAL_W +: VAL_W] == VAL_W'(2)) any_two   = 1'b1;
      if (dice_in[i*VAL_W +: VAL_W] == VAL_W'(3)) any_three = 1'b1;
    end
  end

`ifdef DICE_JUDGE_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMR_W-1:0] timer_q, timer_d;
`endif

  always_comb begin
    // A strobe during EVAL starts the next round; all other flags clear.
    flags_d   = (state_q == EVAL) ? rolled_in : (flags_q | rolled_in);
    state_d   = state_q;
    digit_d   = digit_q;
    pattern_d = pattern_q;
    valid_d   = 1'b0;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;

    if (&flags_d)      state_d = EVAL;
    else if (|flags_d) state_d = COLLECT;
    else               state_d = IDLE;

    if (state_q == EVAL) begin
      valid_d   = 1'b1;
      cnt_d     = cnt_q + CNT_W'(1);
      timeout_d = 1'b0;
      // Without all-equal, any 3 implies some channel is not 3.
      if (all_equal) begin
        digit_d   = {1'b0, dice_in[0 +: VAL_W]};
        pattern_d = 2'd0;
      end else if (any_one && any_two) begin
        pattern_d = 2'd1;
      end else if (any_three) begin
        pattern_d = 2'd2;
      end else begin
        pattern_d = 2'd3;
      end
    end

`ifdef DICE_JUDGE_TIMEOUT_EN
    timer_d = '0;
    if (state_d == COLLECT && state_q == COLLECT) timer_d = timer_q + TMR_W'(1);
    // Completion in the expiry cycle wins over the abort.
    if (state_q == COLLECT && timer_q == TMR_W'(TIMEOUT_CYC - 1) && !(&flags_d)) begin
      flags_d   = '0;
      state_d   = IDLE;
      timer_d   = '0;
      valid_d   = 1'b1;
      pattern_d = 2'd3;
      timeout_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      flags_q   <= '0;
      digit_q   <= '0;
      pattern_q <= 2'd3;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      digit_q   <= digit_d;
      pattern_q <= pattern_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef DICE_JUDGE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign digit        = digit_q;
  assign pattern      = pattern_q;
  assign result_valid = valid_q;
  assign round_cnt    = cnt_q;

endmodule

// File: tb/tb_dice_judge.sv
// tb/tb_dice_judge.sv - self-checking bench for dice_judge, two- and three-channel instances.
// Timeout scenario active when DICE_JUDGE_TIMEOUT_EN is defined.
module tb_dice_judge;

  logic       clk;
  logic       rst;
  logic [5:0] dice2;
  logic [1:0] rolled2;
  logic [8:0] dice3;
  logic [2:0] rolled3;
  logic [3:0] digit2, digit3;
  logic [1:0] pattern2, pattern3;
  logic       rv2, rv3, to2, to3;
  logic [7:0] cnt2, cnt3;

  int n_checks = 0;
  int n_fail   = 0;

  dice_judge #(.N_DICE(2), .VAL_W(3), .CNT_W(8), .TIMEOUT_CYC(10)) u2 (
    .clk(clk), .rst(rst), .dice_in(dice2), .rolled_in(rolled2),
    .digit(digit2), .pattern(pattern2), .result_valid(rv2),
    .round_cnt(cnt2), .timeout(to2)
  );

  dice_judge #(.N_DICE(3), .VAL_W(3), .CNT_W(8), .TIMEOUT_CYC(10)) u3 (
    .clk(clk), .rst(rst), .dice_in(dice3), .rolled_in(rolled3),
    .digit(digit3), .pattern(pattern3), .result_valid(rv3),
    .round_cnt(cnt3), .timeout(to3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: rules in priority order, computed from counts of each face.
  function automatic logic [5:0] judge(input int n, input logic [8:0] dv, input logic [3:0] prev);
    int v[3];
    int c1, c2, c3;
    bit eq;
    c1 = 0; c2 = 0; c3 = 0; eq = 1'b1;
    for (int i = 0; i < n; i++) begin
      v[i] = int'(dv[i*3 +: 3]);
      if (v[i] == 1) c1++;
      if (v[i] == 2) c2++;
      if (v[i] == 3) c3++;
    end
    for (int i = 1; i < n; i++) if (v[i] != v[0]) eq = 1'b0;
    if (eq) return {4'(v[0]), 2'd0};
    if (c1 > 0 && c2 > 0) return {prev, 2'd1};
    if (c3 >= 1 && c3 <= n - 1) return {prev, 2'd2};
    return {prev, 2'd3};
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe2(input logic [1:0] m);
    rolled2 = m;
    cyc;
    rolled2 = '0;
  endtask

  task automatic strobe3(input logic [2:0] m);
    rolled3 = m;
    cyc;
    rolled3 = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) cyc;
    rst = 1'b0;
    n_checks++; if (digit2 !== 4'd0) begin n_fail++; $display("FAIL reset_digit2 got %0d exp 0", digit2); end
    n_checks++; if (pattern2 !== 2'd3) begin n_fail++; $display("FAIL reset_pattern2 got %0d exp 3", pattern2); end
    n_checks++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL reset_rv2 got %0b exp 0", rv2); end
    n_checks++; if (cnt2 !== 8'd0) begin n_fail++; $display("FAIL reset_cnt2 got %0d exp 0", cnt2); end
    n_checks++; if (to2 !== 1'b0) begin n_fail++; $display("FAIL reset_to2 got %0b exp 0", to2); end
    n_checks++; if (pattern3 !== 2'd3) begin n_fail++; $display("FAIL reset_pattern3 got %0d exp 3", pattern3); end
    n_checks++; if (cnt3 !== 8'd0) begin n_fail++; $display("FAIL reset_cnt3 got %0d exp 0", cnt3); end
    cyc;
    n_checks++; if (rv2 !== 1'b0 || rv3 !== 1'b0) begin n_fail++; $display("FAIL reset_idle_rv got %0b/%0b exp 0/0", rv2, rv3); end
  endtask

  task automatic test_basic;
    repeat (4) cyc;
    strobe2(2'b01);
    repeat (3) cyc;
    dice2 = {3'd4, 3'd4};
    strobe2(2'b10);
    n_checks++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL basic_latency rv got %0b exp 0", rv2); end
    cyc;
    n_checks++; if (digit2 !== 4'd4) begin n_fail++; $display("FAIL basic_digit got %0d exp 4", digit2); end
    n_checks++; if (pattern2 !== 2'd0) begin n_fail++; $display("FAIL basic_pattern got %0d exp 0", pattern2); end
    n_checks++; if (rv2 !== 1'b1) begin n_fail++; $display("FAIL basic_rv got %0b exp 1", rv2); end
    n_checks++; if (cnt2 !== 8'd1) begin n_fail++; $display("FAIL basic_cnt got %0d exp 1", cnt2); end
    cyc;
    n_checks++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL basic_rv_pulse got %0b exp 0", rv2); end
    n_checks++; if (digit2 !== 4'd4) begin n_fail++; $display("FAIL basic_digit_hold got %0d exp 4", digit2); end
  endtask

  task automatic test_simultaneous;
    dice2 = {3'd1, 3'd2};
    strobe2(2'b11);
    cyc;
    n_checks++; if (pattern2 !== 2'd1) begin n_fail++; $display("FAIL simul_pattern got %0d exp 1", pattern2); end
    n_checks++; if (digit2 !== 4'd4) begin n_fail++; $display("FAIL simul_digit got %0d exp 4", digit2); end
    n_checks++; if (rv2 !== 1'b1 || cnt2 !== 8'd2) begin n_fail++; $display("FAIL simul_rv_cnt got %0b/%0d exp 1/2", rv2, cnt2); end
    cyc;
    dice2 = {3'd6, 3'd5};
    strobe2(2'b01);
    strobe2(2'b01);
    cyc;
    cyc;
    n_checks++; if (rv2 !== 1'b0 || cnt2 !== 8'd2) begin n_fail++; $display("FAIL repeat_strobe rv/cnt got %0b/%0d exp 0/2", rv2, cnt2); end
    strobe2(2'b10);
    cyc;
    n_checks++; if (pattern2 !== 2'd3 || digit2 !== 4'd4) begin n_fail++; $display("FAIL rule4 pattern/digit got %0d/%0d exp 3/4", pattern2, digit2); end
    n_checks++; if (rv2 !== 1'b1 || cnt2 !== 8'd3) begin n_fail++; $display("FAIL rule4 rv/cnt got %0b/%0d exp 1/3", rv2, cnt2); end
    cyc;
  endtask

  task automatic test_n3;
    dice3 = {3'd6, 3'd5, 3'd3};
    strobe3(3'b111);
    cyc;
    n_checks++; if (pattern3 !== 2'd2 || digit3 !== 4'd0) begin n_fail++; $display("FAIL n3_rule3 pattern/digit got %0d/%0d exp 2/0", pattern3, digit3); end
    n_checks++; if (rv3 !== 1'b1 || cnt3 !== 8'd1) begin n_fail++; $display("FAIL n3_rule3 rv/cnt got %0b/%0d exp 1/1", rv3, cnt3); end
    cyc;
    dice3 = {3'd3, 3'd3, 3'd3};
    strobe3(3'b001);
    strobe3(3'b110);
    cyc;
    n_checks++; if (pattern3 !== 2'd0 || digit3 !== 4'd3) begin n_fail++; $display("FAIL n3_triple pattern/digit got %0d/%0d exp 0/3", pattern3, digit3); end
    n_checks++; if (cnt3 !== 8'd2) begin n_fail++; $display("FAIL n3_triple cnt got %0d exp 2", cnt3); end
    cyc;
    dice3 = {3'd6, 3'd5, 3'd4};
    strobe3(3'b111);
    cyc;
    n_checks++; if (pattern3 !== 2'd3 || digit3 !== 4'd3) begin n_fail++; $display("FAIL n3_rule4 pattern/digit got %0d/%0d exp 3/3", pattern3, digit3); end
    n_checks++; if (cnt3 !== 8'd3) begin n_fail++; $display("FAIL n3_rule4 cnt got %0d exp 3", cnt3); end
    cyc;
  endtask

  task automatic test_eval_strobe;
    dice2 = {3'd6, 3'd6};
    strobe2(2'b01);
    rolled2 = 2'b10;
    cyc;
    rolled2 = 2'b01;
    cyc;
    rolled2 = 2'b00;
    n_checks++; if (rv2 !== 1'b1 || digit2 !== 4'd6 || cnt2 !== 8'd4) begin n_fail++; $display("FAIL eval_strobe round rv/digit/cnt got %0b/%0d/%0d exp 1/6/4", rv2, digit2, cnt2); end
    dice2 = {3'd1, 3'd1};
    strobe2(2'b10);
    n_checks++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL eval_strobe gap rv got %0b exp 0", rv2); end
    cyc;
    n_checks++; if (rv2 !== 1'b1 || digit2 !== 4'd1 || cnt2 !== 8'd5) begin n_fail++; $display("FAIL eval_strobe next rv/digit/cnt got %0b/%0d/%0d exp 1/1/5", rv2, digit2, cnt2); end
    cyc;
  endtask

  task automatic test_random;
    logic [5:0] exp;
    logic [3:0] ed2, ed3;
    logic [7:0] ec2, ec3;
    logic [1:0] m;
    logic [2:0] m3;
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    ed2 = '0; ec2 = '0; ed3 = '0; ec3 = '0;
    for (int r = 0; r < 256; r++) begin
      dice2[2:0] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) dice2[5:3] = dice2[2:0];
      else dice2[5:3] = 3'($urandom_range(0, 7));
      m = 2'($urandom_range(1, 3));
      if (m != 2'b11) begin
        strobe2(m);
        repeat ($urandom_range(0, 3)) cyc;
        if ($urandom_range(0, 1) == 1) strobe2(m);
        strobe2(~m);
      end else begin
        strobe2(m);
      end
      cyc;
      exp = judge(2, {3'b000, dice2}, ed2);
      ed2 = exp[5:2];
      ec2 = ec2 + 8'd1;
      n_checks++; if (digit2 !== ed2) begin n_fail++; $display("FAIL rand2 digit r%0d got %0d exp %0d", r, digit2, ed2); end
      n_checks++; if (pattern2 !== exp[1:0]) begin n_fail++; $display("FAIL rand2 pattern r%0d got %0d exp %0d", r, pattern2, exp[1:0]); end
      n_checks++; if (rv2 !== 1'b1 || to2 !== 1'b0) begin n_fail++; $display("FAIL rand2 rv/to r%0d got %0b/%0b exp 1/0", r, rv2, to2); end
      n_checks++; if (cnt2 !== ec2) begin n_fail++; $display("FAIL rand2 cnt r%0d got %0d exp %0d", r, cnt2, ec2); end
      cyc;
      n_checks++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL rand2 rv_pulse r%0d got %0b exp 0", r, rv2); end
    end
    n_checks++; if (cnt2 !== 8'd0) begin n_fail++; $display("FAIL cnt_wrap got %0d exp 0", cnt2); end
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 3; i++) dice3[i*3 +: 3] = 3'($urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) dice3 = {dice3[2:0], dice3[2:0], dice3[2:0]};
      m3 = 3'($urandom_range(1, 7));
      strobe3(m3);
      if (m3 != 3'b111) strobe3(~m3);
      cyc;
      exp = judge(3, dice3, ed3);
      ed3 = exp[5:2];
      ec3 = ec3 + 8'd1;
      n_checks++; if (digit3 !== ed3 || pattern3 !== exp[1:0]) begin n_fail++; $display("FAIL rand3 digit/pattern r%0d got %0d/%0d exp %0d/%0d", r, digit3, pattern3, ed3, exp[1:0]); end
      n_checks++; if (rv3 !== 1'b1 || cnt3 !== ec3) begin n_fail++; $display("FAIL rand3 rv/cnt r%0d got %0b/%0d exp 1/%0d", r, rv3, cnt3, ec3); end
      cyc;
    end
  endtask

  task automatic test_timeout;
    rst = 1'b1;
    cyc;
    rst = 1'b0;
`ifdef DICE_JUDGE_TIMEOUT_EN
    strobe2(2'b01);
    for (int k = 0; k < 9; k++) begin
      cyc;
      n_checks++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL timeout_early k%0d rv got %0b exp 0", k, rv2); end
    end
    cyc;
    n_checks++; if (rv2 !== 1'b1 || to2 !== 1'b1) begin n_fail++; $display("FAIL timeout_abort rv/to got %0b/%0b exp 1/1", rv2, to2); end
    n_checks++; if (pattern2 !== 2'd3 || digit2 !== 4'd0 || cnt2 !== 8'd0) begin n_fail++; $display("FAIL timeout_abort pat/dig/cnt got %0d/%0d/%0d exp 3/0/0", pattern2, digit2, cnt2); end
    cyc;
    n_checks++; if (rv2 !== 1'b0 || to2 !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky rv/to got %0b/%0b exp 0/1", rv2, to2); end
    dice2 = {3'd4, 3'd4};
    strobe2(2'b01);
    repeat (9) cyc;
    strobe2(2'b10);
    n_checks++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL expiry_complete eval rv got %0b exp 0", rv2); end
    cyc;
    n_checks++; if (rv2 !== 1'b1 || to2 !== 1'b0 || cnt2 !== 8'd1) begin n_fail++; $display("FAIL expiry_complete rv/to/cnt got %0b/%0b/%0d exp 1/0/1", rv2, to2, cnt2); end
    n_checks++; if (pattern2 !== 2'd0 || digit2 !== 4'd4) begin n_fail++; $display("FAIL expiry_complete pat/dig got %0d/%0d exp 0/4", pattern2, digit2); end
    cyc;
`else
    strobe2(2'b01);
    for (int k = 0; k < 30; k++) begin
      cyc;
      n_checks++; if (rv2 !== 1'b0 || to2 !== 1'b0) begin n_fail++; $display("FAIL no_timeout k%0d rv/to got %0b/%0b exp 0/0", k, rv2, to2); end
    end
    dice2 = {3'd4, 3'd4};
    strobe2(2'b10);
    cyc;
    n_checks++; if (rv2 !== 1'b1 || cnt2 !== 8'd1 || digit2 !== 4'd4) begin n_fail++; $display("FAIL long_collect rv/cnt/dig got %0b/%0d/%0d exp 1/1/4", rv2, cnt2, digit2); end
    cyc;
`endif
  endtask

  task automatic test_reset_mid;
    dice2 = {3'd5, 3'd5};
    strobe2(2'b01);
    strobe3(3'b001);
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    n_checks++; if (digit2 !== 4'd0 || pattern2 !== 2'd3) begin n_fail++; $display("FAIL midreset dig/pat got %0d/%0d exp 0/3", digit2, pattern2); end
    n_checks++; if (rv2 !== 1'b0 || cnt2 !== 8'd0 || to2 !== 1'b0) begin n_fail++; $display("FAIL midreset rv/cnt/to got %0b/%0d/%0b exp 0/0/0", rv2, cnt2, to2); end
    strobe2(2'b10);
    cyc;
    n_checks++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL midreset flag_cleared rv got %0b exp 0", rv2); end
    cyc;
    n_checks++; if (rv2 !== 1'b0 || cnt2 !== 8'd0) begin n_fail++; $display("FAIL midreset no_round rv/cnt got %0b/%0d exp 0/0", rv2, cnt2); end
    strobe2(2'b01);
    cyc;
    n_checks++; if (rv2 !== 1'b1 || cnt2 !== 8'd1 || digit2 !== 4'd5) begin n_fail++; $display("FAIL midreset resume rv/cnt/dig got %0b/%0d/%0d exp 1/1/5", rv2, cnt2, digit2); end
    cyc;
  endtask

  initial begin
    rst = 1'b1;
    dice2 = '0;
    rolled2 = '0;
    dice3 = '0;
    rolled3 = '0;
    test_reset;
    test_basic;
    test_simultaneous;
    test_n3;
    test_eval_strobe;
    test_random;
    test_timeout;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
